// File: rtl/layer_conf_sequencer.sv
// layer_conf_sequencer: walks a host-written layer table through the
// MUXDC config handshake, then starts each layer on the compute array.
//
// Ports
//   LCS_Clk, LCS_Reset           clock, synchronous active-high reset
//   LCS_Cfg_Wr/Addr/W_Colums/W_ROXCL
//                                host table write (accepted in IDLE)
//   LCS_Num_Layers_M1, LCS_Start layer count - 1 and sequence start
//   LCS_Abort                    return to IDLE from any state
//   LCS_Muxdc_Set_Conf           config request pulse to MUXDC
//   LCS_Muxdc_Set_Conf_Already   MUXDC config-complete flag
//   LCS_Muxdc_Set_Conf_Ok        acknowledge pulse to MUXDC
//   LCS_Muxdc_W_Colums/W_ROXCL   current layer geometry
//   LCS_Layer_Start              layer start pulse to the array
//   LCS_Layer_Done               layer-complete pulse from the array
//   LCS_Layer_Idx                active layer index
//   LCS_Busy, LCS_Done, LCS_Error
//                                status: running, finished, timed out
module layer_conf_sequencer #(
  parameter int NUM_LAYERS_MAX      = 4,
  parameter int LAYER_IDX_W         = 2,
  parameter int BITWIDTH_W_COLUMS   = 4,
  parameter int BITWIDTH_MAX_W_SIZE = 9,
  parameter int TIMEOUT_W           = 10,
  parameter int TIMEOUT_CYCLES      = 1023
) (
  input  logic                           LCS_Clk,
  input  logic                           LCS_Reset,
  input  logic                           LCS_Cfg_Wr,
  input  logic [LAYER_IDX_W-1:0]         LCS_Cfg_Addr,
  input  logic [BITWIDTH_W_COLUMS-1:0]   LCS_Cfg_W_Colums,
  input  logic [BITWIDTH_MAX_W_SIZE-1:0] LCS_Cfg_W_ROXCL,
  input  logic [LAYER_IDX_W-1:0]         LCS_Num_Layers_M1,
  input  logic                           LCS_Start,
  input  logic                           LCS_Abort,
  output logic                           LCS_Muxdc_Set_Conf,
  input  logic                           LCS_Muxdc_Set_Conf_Already,
  output logic                           LCS_Muxdc_Set_Conf_Ok,
  output logic [BITWIDTH_W_COLUMS-1:0]   LCS_Muxdc_W_Colums,
  output logic [BITWIDTH_MAX_W_SIZE-1:0] LCS_Muxdc_W_ROXCL,
  output logic                           LCS_Layer_Start,
  input  logic                           LCS_Layer_Done,
  output logic [LAYER_IDX_W-1:0]         LCS_Layer_Idx,
  output logic                           LCS_Busy,
  output logic                           LCS_Done,
  output logic                           LCS_Error
);

  localparam logic [TIMEOUT_W-1:0] TO_LIM =
    TIMEOUT_W'(TIMEOUT_CYCLES);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_CONF_REQ,
    S_CONF_WAIT,
    S_CONF_ACK,
    S_RUN,
    S_WAIT_DONE,
    S_FINISH,
    S_ERROR
  } state_e;

  state_e state_q, state_d;

  logic [BITWIDTH_W_COLUMS-1:0]
    tbl_col_q [NUM_LAYERS_MAX];
  logic [BITWIDTH_MAX_W_SIZE-1:0]
    tbl_rox_q [NUM_LAYERS_MAX];

  logic [LAYER_IDX_W-1:0]         idx_q;
  logic [LAYER_IDX_W-1:0]         num_q;
  logic [TIMEOUT_W-1:0]           cnt_q;
  logic [BITWIDTH_W_COLUMS-1:0]   col_q;
  logic [BITWIDTH_MAX_W_SIZE-1:0] rox_q;

  logic last_layer;
  logic tbl_we;
  logic seq_go;
  logic idx_adv;

  assign last_layer = (idx_q == num_q);
  assign tbl_we  = (state_q == S_IDLE) && LCS_Cfg_Wr;

  // Index updates key off the chosen transition so
  // that Abort (which overrides it) blocks them too.
  assign seq_go  = (state_q == S_IDLE) &&
                   (state_d == S_LOAD);
  assign idx_adv = (state_q == S_WAIT_DONE) &&
                   (state_d == S_LOAD);

  // State register
  always_ff @(posedge LCS_Clk) begin
    if (LCS_Reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (LCS_Start) state_d = S_LOAD;
      end
      S_LOAD: begin
        state_d = S_CONF_REQ;
      end
      S_CONF_REQ: begin
        state_d = S_CONF_WAIT;
      end
      S_CONF_WAIT: begin
        if (LCS_Muxdc_Set_Conf_Already)
          state_d = S_CONF_ACK;
        else if (cnt_q == TO_LIM)
          state_d = S_ERROR;
      end
      S_CONF_ACK: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (LCS_Layer_Done)
          state_d = last_layer ? S_FINISH
                               : S_LOAD;
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      S_ERROR: begin
        state_d = S_ERROR;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (LCS_Abort) state_d = S_IDLE;
  end

  // Layer table, index, timeout and geometry registers
  always_ff @(posedge LCS_Clk) begin
    if (LCS_Reset) begin
      for (int i = 0; i < NUM_LAYERS_MAX; i++) begin
        tbl_col_q[i] <= '0;
        tbl_rox_q[i] <= '0;
      end
      idx_q <= '0;
      num_q <= '0;
      cnt_q <= '0;
      col_q <= '0;
      rox_q <= '0;
    end else begin
      if (tbl_we) begin
        tbl_col_q[LCS_Cfg_Addr] <= LCS_Cfg_W_Colums;
        tbl_rox_q[LCS_Cfg_Addr] <= LCS_Cfg_W_ROXCL;
      end
      if (seq_go) begin
        num_q <= LCS_Num_Layers_M1;
        idx_q <= '0;
      end else if (idx_adv) begin
        idx_q <= idx_q + 1'b1;
      end
      if (state_q == S_LOAD) begin
        col_q <= tbl_col_q[idx_q];
        rox_q <= tbl_rox_q[idx_q];
      end
      if (state_q == S_CONF_REQ)
        cnt_q <= '0;
      else if (state_q == S_CONF_WAIT)
        cnt_q <= cnt_q + 1'b1;
    end
  end

  // Output decode
  always_comb begin
    LCS_Muxdc_Set_Conf    = 1'b0;
    LCS_Muxdc_Set_Conf_Ok = 1'b0;
    LCS_Layer_Start       = 1'b0;
    LCS_Done              = 1'b0;
    LCS_Busy              = 1'b1;
    LCS_Error             = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        LCS_Busy = 1'b0;
      end
      S_CONF_REQ: begin
        LCS_Muxdc_Set_Conf = 1'b1;
      end
      S_CONF_ACK: begin
        LCS_Muxdc_Set_Conf_Ok = 1'b1;
      end
      S_RUN: begin
        LCS_Layer_Start = 1'b1;
      end
      S_FINISH: begin
        LCS_Done = 1'b1;
      end
      S_ERROR: begin
        LCS_Busy  = 1'b0;
        LCS_Error = 1'b1;
      end
      default: begin
      end
    endcase
    if (LCS_Abort) begin
      LCS_Muxdc_Set_Conf    = 1'b0;
      LCS_Muxdc_Set_Conf_Ok = 1'b0;
      LCS_Layer_Start       = 1'b0;
      LCS_Done              = 1'b0;
    end
  end

  assign LCS_Muxdc_W_Colums = col_q;
  assign LCS_Muxdc_W_ROXCL  = rox_q;
  assign LCS_Layer_Idx      = idx_q;

endmodule
